// File: rtl/eth_10g_lf_pkg.sv
// Shared definitions for the 10G RX link fault detector.
//   - link fault status encodings driven on link_fault_status
//   - XGMII characters that make up a fault sequence ordered set
//   - col_seq_t: per-column classification result
// The col_seq_t values match the status encodings so a declared fault
// can copy the sequence type directly into the status register.
package eth_10g_lf_pkg;

  localparam logic [1:0] LF_NONE   = 2'b00;
  localparam logic [1:0] LF_LOCAL  = 2'b01;
  localparam logic [1:0] LF_REMOTE = 2'b10;

  localparam logic [7:0] SEQ_CHAR = 8'h9C;
  localparam logic [7:0] LF_CODE  = 8'h01;
  localparam logic [7:0] RF_CODE  = 8'h02;

  typedef enum logic [1:0] {
    COL_NONE   = 2'b00,
    COL_LOCAL  = 2'b01,
    COL_REMOTE = 2'b10
  } col_seq_t;

endpackage

// File: rtl/eth_10g_lf_column_decode.sv
// Combinational classifier for one 4-lane XGMII column.
// Ports:
//   data     in  32  lanes 0..3 of the column (lane i = bits [8i+7:8i])
//   ctrl     in   4  per-lane control flags
//   seq_type out  col_seq_t  LOCAL/REMOTE for a valid fault sequence, else NONE
// A 0x9C column with any other payload is an ordinary column.
module eth_10g_lf_column_decode
  import eth_10g_lf_pkg::*;
(
  input  logic [31:0] data,
  input  logic [3:0]  ctrl,
  output col_seq_t    seq_type
);

  always_comb begin
    seq_type = COL_NONE;
    if (ctrl == 4'b0001 && data[7:0] == SEQ_CHAR && data[23:8] == 16'h0000) begin
      if (data[31:24] == LF_CODE)
        seq_type = COL_LOCAL;
      else if (data[31:24] == RF_CODE)
        seq_type = COL_REMOTE;
    end
  end

endmodule

// File: rtl/eth_10g_link_fault_detect_rx.sv
// 10G MAC RX link fault detector (XGMII, 64-bit / two columns per clock).
// Ports:
//   clk               in   1  MAC RX clock
//   reset_n           in   1  synchronous active-low reset
//   xgmii_rx_data     in  64  column A = lanes 0-3, column B = lanes 4-7
//   xgmii_rx_ctrl     in   8  per-lane control flags
//   link_fault_status out  2  00 none, 01 local, 10 remote (registered)
//   seq_detected      out  1  pulse for each cycle carrying a fault sequence
// Column A is applied to the state first and column B sees the result, so
// one clock can advance the counters twice.
module eth_10g_link_fault_detect_rx
  import eth_10g_lf_pkg::*;
#(
  parameter int COL_WINDOW    = 128,
  parameter int SEQ_THRESHOLD = 4
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] xgmii_rx_data,
  input  logic [7:0]  xgmii_rx_ctrl,
  output logic [1:0]  link_fault_status,
  output logic        seq_detected
);

  localparam int CW = $clog2(COL_WINDOW + 1);
  localparam int SW = $clog2(SEQ_THRESHOLD + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COL_WINDOW);
  localparam logic [SW-1:0] SEQ_MAX = SW'(SEQ_THRESHOLD);

  typedef struct packed {
    logic [1:0]    status;
    col_seq_t      last_type;
    logic [SW-1:0] seq_cnt;
    logic [CW-1:0] col_cnt;
  } lf_state_t;

  col_seq_t  col_type [2];
  lf_state_t st, st_a, st_next;

  for (genvar g = 0; g < 2; g++) begin : g_col
    eth_10g_lf_column_decode u_dec (
      .data     (xgmii_rx_data[32*g +: 32]),
      .ctrl     (xgmii_rx_ctrl[4*g +: 4]),
      .seq_type (col_type[g])
    );
  end

  // One column's worth of state evolution.
  function automatic lf_state_t col_update(input lf_state_t s, input col_seq_t t);
    lf_state_t n;
    n = s;
    if (t != COL_NONE) begin
      if (t == s.last_type) begin
        if (s.seq_cnt < SEQ_MAX)
          n.seq_cnt = s.seq_cnt + 1'b1;
      end else begin
        n.seq_cnt   = SW'(1);
        n.last_type = t;
      end
      n.col_cnt = '0;
      if (n.seq_cnt == SEQ_MAX)
        n.status = t;
    end else begin
      if (s.col_cnt < COL_MAX)
        n.col_cnt = s.col_cnt + 1'b1;
      // Saturated counter keeps re-clearing; harmless since nothing is set.
      if (n.col_cnt == COL_MAX) begin
        n.seq_cnt   = '0;
        n.last_type = COL_NONE;
        n.status    = LF_NONE;
      end
    end
    return n;
  endfunction

  always_comb begin
    st_a    = col_update(st, col_type[0]);
    st_next = col_update(st_a, col_type[1]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st           <= '0;
      seq_detected <= 1'b0;
    end else begin
      st           <= st_next;
      seq_detected <= (col_type[0] != COL_NONE) || (col_type[1] != COL_NONE);
    end
  end

  assign link_fault_status = st.status;

endmodule
